// File: rtl/approx_seq_mac.sv
// Iterative shift-and-add multiply-accumulate with a saturating accumulator.
// Define APPROX_LSB_EN to make the partial-product adder a lower-part-OR adder.
module approx_seq_mac #(
    parameter int W     = 8,
    parameter int K     = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);

    // Handshake: an input transfer happens on a rising edge where in_valid && in_ready;
    // an output transfer happens on a rising edge where out_valid && out_ready.
    // out_valid, acc and sat hold steady until that output transfer.

    localparam int PW = 2 * W;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             clr_q;
    logic [PW-1:0]    p;
    logic [IW-1:0]    i;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    p_nx;
    logic             carry;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_nx;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_cout(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

    assign in_ready = (state == S_IDLE);

    // Partial product for the current multiplier bit, already aligned to its weight.
    always_comb begin
        pp = '0;
        if (b_q[i]) begin
            pp = {{W{1'b0}}, a_q} << i;
        end
    end

    // Partial-product adder: a ripple of full-adder cells.
    always_comb begin
        p_nx  = '0;
        carry = 1'b0;
        for (int j = 0; j < PW; j++) begin
`ifdef APPROX_LSB_EN
            if (j < K) begin
                p_nx[j] = p[j] | pp[j];
            end else begin
                if (j == K) begin
                    carry = p[K-1] & pp[K-1];
                end
                p_nx[j] = fa_sum(p[j], pp[j], carry);
                carry   = fa_cout(p[j], pp[j], carry);
            end
`else
            p_nx[j] = fa_sum(p[j], pp[j], carry);
            carry   = fa_cout(p[j], pp[j], carry);
`endif
        end
    end

    // Exact accumulate with one guard bit to detect the clamp.
    always_comb begin
        acc_base = clr_q ? '0 : acc;
        acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - PW){1'b0}}, p};
        acc_ovf  = acc_sum[ACC_W];
        acc_nx   = acc_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            clr_q     <= 1'b0;
            p         <= '0;
            i         <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        clr_q <= in_clr;
                        p     <= '0;
                        i     <= '0;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Always W steps, zero multiplier bits included, for fixed latency.
                    p <= p_nx;
                    i <= i + 1'b1;
                    if (i == IW'(W - 1)) begin
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc       <= acc_nx;
                    sat       <= clr_q ? acc_ovf : (sat | acc_ovf);
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
